armaria_io_controller: RTL and testbench

ARMARIA_IO_CONTROLLER -- requirements
Module: armaria_io_controller

---
 rtl/armaria_io_controller.sv | 154 +++++++++++++++
 tb/tb_armaria_io_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armaria_io_controller.sv
// CPU I/O controller: input capture and halt/resume handshake FSM, plus an
// output FIFO that drains into latched display channels at a paced rate.
module armaria_io_controller #(
    parameter int DATA_WIDTH  = 32,
    parameter int IO_WIDTH    = 16,
    parameter int CHANNELS    = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 4,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                           fast_clock,
    input  logic                           reset,
    input  logic                           is_input,
    input  logic                           is_output,
    input  logic                           halt_request,
    input  logic [CW-1:0]                  channel,
    input  logic [DATA_WIDTH-1:0]          out_data,
    input  logic [IO_WIDTH-1:0]            sw,
    input  logic                           confirmation,
    input  logic                           resume,
    output logic                           enable,
    output logic [DATA_WIDTH-1:0]          in_data,
    output logic [CHANNELS*DATA_WIDTH-1:0] display,
    output logic [IO_WIDTH-1:0]            rled,
    output logic [AW:0]                    fifo_count,
    output logic [1:0]                     state
);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IN = 2'd1,
        S_HALTED  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_conf_prev;
    logic                  r_resume_prev;
    logic [DATA_WIDTH-1:0] r_in_data;
    logic [DATA_WIDTH-1:0] r_disp [CHANNELS];
    logic [HW-1:0]         r_hold;
    logic [AW-1:0]         r_head;
    logic [AW-1:0]         r_tail;
    logic [AW:0]           r_count;
    logic [CW-1:0]         r_mem_ch   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];

    logic                  w_conf_edge;
    logic                  w_resume_edge;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_head_ch;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_valid;

    assign w_conf_edge   = confirmation & ~r_conf_prev;
    assign w_resume_edge = resume & ~r_resume_prev;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = (r_state == S_IDLE) && is_output && !is_input && !halt_request && !w_full;
    assign w_pop   = !w_empty && (r_hold == '0);

    assign w_head_ch    = r_mem_ch[r_head];
    assign w_head_data  = r_mem_data[r_head];
    assign w_head_valid = (int'(w_head_ch) < CHANNELS);

    // NOTE: every path assigns enable after a default, so no latch is inferred.
    always_comb begin
        enable = 1'b0;
        case (r_state)
            S_IDLE:    enable = !(halt_request || is_input || (is_output && w_full));
            S_RELEASE: enable = 1'b1;
            default:   enable = 1'b0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_in_data     <= '0;
            r_conf_prev   <= 1'b1;
            r_resume_prev <= 1'b1;
        end else begin
            r_conf_prev   <= confirmation;
            r_resume_prev <= resume;
            case (r_state)
                S_IDLE: begin
                    if (halt_request)  r_state <= S_HALTED;
                    else if (is_input) r_state <= S_WAIT_IN;
                end
                S_WAIT_IN: begin
                    if (w_conf_edge) begin
                        r_in_data <= DATA_WIDTH'(sw);
                        r_state   <= S_RELEASE;
                    end
                end
                S_HALTED: begin
                    if (w_resume_edge) r_state <= S_RELEASE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; r_count alone decides which entries are live.
    always_ff @(posedge fast_clock) begin
        if (w_push) begin
            r_mem_ch[r_tail]   <= channel;
            r_mem_data[r_tail] <= out_data;
        end
    end

    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_hold  <= '0;
            for (int k = 0; k < CHANNELS; k++) r_disp[k] <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // Entries addressed to a non-existent channel are dropped without starting a hold.
            if (w_pop && w_head_valid) r_hold <= HW'(HOLD_CYCLES - 1);
            else if (r_hold != '0)     r_hold <= r_hold - HW'(1);
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_pop && int'(w_head_ch) == k) r_disp[k] <= w_head_data;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_disp
        assign display[k*DATA_WIDTH +: DATA_WIDTH] = r_disp[k];
    end

    assign rled       = r_disp[0][IO_WIDTH-1:0];
    assign in_data    = r_in_data;
    assign fifo_count = r_count;
    assign state      = r_state;

endmodule

// File: tb/tb_armaria_io_controller.sv
// Scoreboard bench for armaria_io_controller: directed stimulus queues expected
// display/input captures; a negedge monitor compares whenever those outputs change.
module tb_armaria_io_controller;

    localparam int DW    = 32;
    localparam int IOW   = 16;
    localparam int CH    = 3;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int CW    = 2;

    logic            fast_clock = 1'b0;
    logic            reset;
    logic            is_input;
    logic            is_output;
    logic            halt_request;
    logic [CW-1:0]   channel;
    logic [DW-1:0]   out_data;
    logic [IOW-1:0]  sw;
    logic            confirmation;
    logic            resume;
    logic            enable;
    logic [DW-1:0]   in_data;
    logic [CH*DW-1:0] display;
    logic [IOW-1:0]  rled;
    logic [2:0]      fifo_count;
    logic [1:0]      state;

    typedef struct {
        int          ch;
        logic [DW-1:0] data;
    } disp_exp_t;

    disp_exp_t     exp_disp[$];
    logic [DW-1:0] exp_in[$];
    disp_exp_t     e;
    logic [DW-1:0] e_in;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            st;

    armaria_io_controller #(
        .DATA_WIDTH(DW), .IO_WIDTH(IOW), .CHANNELS(CH),
        .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)
    ) dut (
        .fast_clock(fast_clock), .reset(reset),
        .is_input(is_input), .is_output(is_output), .halt_request(halt_request),
        .channel(channel), .out_data(out_data), .sw(sw),
        .confirmation(confirmation), .resume(resume),
        .enable(enable), .in_data(in_data), .display(display), .rled(rled),
        .fifo_count(fifo_count), .state(state)
    );

    always #5 fast_clock = ~fast_clock;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: any display or in_data change must match the head of its expectation queue.
    logic [CH*DW-1:0] prev_disp;
    logic [DW-1:0]    prev_in;
    always @(negedge fast_clock) begin
        if (reset) begin
            prev_disp = display;
            prev_in   = in_data;
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (display[k*DW +: DW] !== prev_disp[k*DW +: DW]) begin
                    if (exp_disp.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL display_unexpected: channel %0d got 0x%0h, no write pending",
                                 k, display[k*DW +: DW]);
                    end else begin
                        e = exp_disp.pop_front();
                        check("display_channel", k, e.ch);
                        check("display_data", display[k*DW +: DW], e.data);
                    end
                end
            end
            prev_disp = display;
            if (in_data !== prev_in) begin
                if (exp_in.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL in_data_unexpected: got 0x%0h, no capture pending", in_data);
                end else begin
                    e_in = exp_in.pop_front();
                    check("in_data_capture", in_data, e_in);
                end
                prev_in = in_data;
            end
        end
    end

    task automatic tick();
        @(posedge fast_clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one output word, hold it until enable, and record the expected display write.
    task automatic send_word(input int ch, input logic [DW-1:0] d, output int stalls);
        is_output = 1'b1;
        channel   = CW'(ch);
        out_data  = d;
        stalls    = 0;
        #1;
        while (!enable && stalls < 50) begin
            tick();
            stalls++;
        end
        if (!enable) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: word 0x%0h never accepted after %0d cycles", d, stalls);
        end
        if (ch < CH) exp_disp.push_back('{ch, d});
        tick();
    endtask

    task automatic check_display_zero(input string name);
        for (int k = 0; k < CH; k++) check(name, display[k*DW +: DW], '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; is_input = 1'b0; is_output = 1'b0; halt_request = 1'b0;
        confirmation = 1'b1; resume = 1'b0; channel = '0; out_data = '0; sw = '0;
        repeat (2) @(posedge fast_clock);
        #1;
        check("reset_state", state, 0);
        check("reset_count", fifo_count, 0);
        check_display_zero("reset_display");
        check("reset_rled", rled, 0);
        check("reset_in_data", in_data, 0);
        reset = 1'b0;
        #1;
        check("enable_after_reset", enable, 1);

        // Output ordering and hold pacing.
        send_word(0, 32'd5, st);
        send_word(1, 32'd7, st);
        check("order_ch0_first", display[0 +: DW], 5);
        send_word(0, 32'd9, st);
        is_output = 1'b0;
        ticks(2);
        check("order_ch1_held_off", display[DW +: DW], 0);
        tick();
        check("order_ch1_after_hold", display[DW +: DW], 7);
        ticks(3);
        check("order_ch0_held_off", display[0 +: DW], 5);
        tick();
        check("order_ch0_second", display[0 +: DW], 9);
        check("order_rled", rled, 16'h0009);
        check("order_count_empty", fifo_count, 0);

        // Full stall: lead word starts a hold so the next four fill the FIFO.
        ticks(4);
        send_word(0, 32'hA0, st);
        send_word(1, 32'hB1, st);
        send_word(0, 32'hC2, st);
        send_word(1, 32'hD3, st);
        send_word(0, 32'hE4, st);
        check("full_count", fifo_count, DEPTH);
        check("full_enable_low", enable, 0);
        send_word(1, 32'hF5, st);
        check("full_stall_cycles", st, 1);
        check("full_count_after_fifth", fifo_count, DEPTH);
        is_output = 1'b0;
        for (int i = 0; i < 40 && fifo_count != 0; i++) tick();
        check("full_drained", fifo_count, 0);
        ticks(4);

        // Input capture on confirmation edge.
        sw = 16'hBEEF; confirmation = 1'b0; is_input = 1'b1;
        #1;
        check("in_enable_idle_req", enable, 0);
        tick();
        check("in_state_wait", state, 1);
        check("in_enable_wait", enable, 0);
        ticks(2);
        check("in_still_wait", state, 1);
        exp_in.push_back(32'h0000BEEF);
        confirmation = 1'b1;
        tick();
        check("in_state_release", state, 3);
        check("in_enable_release", enable, 1);
        check("in_data_value", in_data, 32'h0000BEEF);
        is_input = 1'b0;
        tick();
        check("in_state_idle", state, 0);
        check("in_enable_idle", enable, 1);

        // Halt beats input and output; confirmation ignored while halted.
        halt_request = 1'b1; is_input = 1'b1; is_output = 1'b1; channel = '0; out_data = 32'h66;
        #1;
        check("halt_enable_req", enable, 0);
        tick();
        check("halt_state", state, 2);
        check("halt_no_push", fifo_count, 0);
        is_output = 1'b0; confirmation = 1'b0;
        tick();
        confirmation = 1'b1;
        tick();
        check("halt_ignores_confirm", state, 2);
        check("halt_in_data_kept", in_data, 32'h0000BEEF);
        resume = 1'b1;
        tick();
        check("halt_release", state, 3);
        check("halt_release_enable", enable, 1);
        halt_request = 1'b0; is_input = 1'b0;
        tick();
        check("halt_back_idle", state, 0);

        // Reset mid-WAIT_IN with queued words and confirmation held high.
        sw = 16'h1234;
        send_word(0, 32'h11, st);
        send_word(1, 32'h22, st);
        send_word(0, 32'h33, st);
        send_word(1, 32'h44, st);
        is_input = 1'b1;
        tick();
        check("prio_input_over_output", state, 1);
        check("queued_count", fifo_count, 3);
        exp_disp.delete();
        is_output = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_state", state, 0);
        check("midrst_count", fifo_count, 0);
        check_display_zero("midrst_display");
        check("midrst_rled", rled, 0);
        check("midrst_in_data", in_data, 0);
        ticks(2);
        reset = 1'b0;
        ticks(3);
        check("post_rst_wait", state, 1);
        check("post_rst_no_capture", in_data, 0);
        check("post_rst_enable", enable, 0);
        exp_in.push_back(32'h00001234);
        confirmation = 1'b0;
        tick();
        confirmation = 1'b1;
        tick();
        check("post_rst_capture", in_data, 32'h00001234);
        is_input = 1'b0;
        tick();

        // Invalid channel is discarded without starting a hold.
        send_word(3, 32'hDEAD, st);
        send_word(2, 32'h77, st);
        check_display_zero("invalid_no_write");
        tick();
        check("valid_after_invalid", display[2*DW +: DW], 32'h77);
        check("invalid_ch0_unchanged", display[0 +: DW], 0);
        check("invalid_ch1_unchanged", display[DW +: DW], 0);
        is_output = 1'b0;
        ticks(5);
        check("final_count", fifo_count, 0);
        check("pending_display_writes", exp_disp.size(), 0);
        check("pending_input_captures", exp_in.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
